// File: rtl/cpu_stack_pkg.sv
// Shared widths, default depth and entry layout for the CPU operand stack.
// Consumers import cpu_stack_pkg::*; see cpu_stack_unit for the CPU_STACK_FWD_EN option.
package cpu_stack_pkg;

  localparam int ST_ENTRY_W       = 35;
  localparam int ST_POP_W         = 11;
  localparam int ST_TAG_W         = 3;
  localparam int ST_DEPTH_DEFAULT = 1024;

  typedef struct packed {
    logic [ST_TAG_W-1:0]            tag;
    logic [ST_ENTRY_W-ST_TAG_W-1:0] data;
  } st_entry_t;

endpackage

// File: rtl/cpu_stack_ram.sv
// Stack storage: DEPTH x 35-bit register array, one synchronous write port,
// two asynchronous read ports. Contents are never reset.
module cpu_stack_ram
  import cpu_stack_pkg::*;
#(
  parameter int DEPTH = ST_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [ST_ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]         raddr0,
  input  logic [AW-1:0]         raddr1,
  output logic [ST_ENTRY_W-1:0] rdata0,
  output logic [ST_ENTRY_W-1:0] rdata1
);

  st_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/cpu_stack_unit.sv
// Architectural operand stack: commits pop-then-push each cycle, exposes the top two
// entries, depth and sticky over/underflow. CPU_STACK_FWD_EN shows the post-commit view.
module cpu_stack_unit
  import cpu_stack_pkg::*;
#(
  parameter int DEPTH = ST_DEPTH_DEFAULT,
  parameter int PTR_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st__push_5a,
  input  logic [ST_POP_W-1:0]   st__to_pop_5a,
  input  logic [ST_ENTRY_W-1:0] st__to_push_5a,
  output logic [ST_ENTRY_W-1:0] st__tos0,
  output logic [ST_ENTRY_W-1:0] st__tos1,
  output logic                  st__tos0_vld,
  output logic                  st__tos1_vld,
  output logic [PTR_W-1:0]      st__depth,
  output logic                  st__uflow,
  output logic                  st__oflow
);

  localparam int               AW      = $clog2(DEPTH);
  localparam int               CMP_W   = (PTR_W > ST_POP_W) ? PTR_W : ST_POP_W;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [PTR_W-1:0]      sp_q, sp_d;
  logic                  uflow_q, uflow_d;
  logic                  oflow_q, oflow_d;

  logic [PTR_W-1:0]      sp_mid, sp_next, sp_view;
  logic                  uflow_hit, push_ok;
  logic                  ram_we;
  logic [AW-1:0]         ram_waddr, ram_raddr0, ram_raddr1;
  logic [ST_ENTRY_W-1:0] ram_rdata0, ram_rdata1;
  logic [ST_ENTRY_W-1:0] tos0_raw;

  // Pop is clamped to the current depth; the push then lands on the clamped pointer.
  always_comb begin
    uflow_hit = 1'b0;
    sp_mid    = '0;
    if (CMP_W'(st__to_pop_5a) > CMP_W'(sp_q)) begin
      uflow_hit = 1'b1;
    end else begin
      sp_mid = sp_q - PTR_W'(st__to_pop_5a);
    end
    push_ok = st__push_5a && (sp_mid < DEPTH_P);
    sp_next = push_ok ? (sp_mid + PTR_W'(1)) : sp_mid;

    sp_d    = rst ? '0   : sp_next;
    uflow_d = rst ? 1'b0 : (uflow_q | uflow_hit);
    oflow_d = rst ? 1'b0 : (oflow_q | (st__push_5a & ~push_ok));

    ram_we    = push_ok & ~rst;
    ram_waddr = AW'(sp_mid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      uflow_q <= 1'b0;
      oflow_q <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      uflow_q <= uflow_d;
      oflow_q <= oflow_d;
    end
  end

  cpu_stack_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (ram_waddr),
    .wdata  (st__to_push_5a),
    .raddr0 (ram_raddr0),
    .raddr1 (ram_raddr1),
    .rdata0 (ram_rdata0),
    .rdata1 (ram_rdata1)
  );

  // A forwarded push occupies sp_next-1, so tos0 comes from the input while
  // tos1 (sp_next-2 == sp_mid-1) is already correct in the array.
  always_comb begin
`ifdef CPU_STACK_FWD_EN
    sp_view  = rst ? '0 : sp_next;
    tos0_raw = ram_we ? st__to_push_5a : ram_rdata0;
`else
    sp_view  = sp_q;
    tos0_raw = ram_rdata0;
`endif
    ram_raddr0   = AW'(sp_view - PTR_W'(1));
    ram_raddr1   = AW'(sp_view - PTR_W'(2));
    st__tos0_vld = (sp_view != '0);
    st__tos1_vld = (sp_view >= PTR_W'(2));
    st__tos0     = st__tos0_vld ? tos0_raw   : '0;
    st__tos1     = st__tos1_vld ? ram_rdata1 : '0;
    st__depth    = sp_view;
  end

  assign st__uflow = uflow_q;
  assign st__oflow = oflow_q;

endmodule

// File: tb/tb_cpu_stack_unit.sv
// Directed self-checking bench for cpu_stack_unit; expectations are hand-computed.
module tb_cpu_stack_unit;

  logic        clk;
  logic        rst;
  logic        st__push_5a;
  logic [10:0] st__to_pop_5a;
  logic [34:0] st__to_push_5a;
  logic [34:0] st__tos0;
  logic [34:0] st__tos1;
  logic        st__tos0_vld;
  logic        st__tos1_vld;
  logic [10:0] st__depth;
  logic        st__uflow;
  logic        st__oflow;

  int checks   = 0;
  int failures = 0;

  cpu_stack_unit dut (
    .clk            (clk),
    .rst            (rst),
    .st__push_5a    (st__push_5a),
    .st__to_pop_5a  (st__to_pop_5a),
    .st__to_push_5a (st__to_push_5a),
    .st__tos0       (st__tos0),
    .st__tos1       (st__tos1),
    .st__tos0_vld   (st__tos0_vld),
    .st__tos1_vld   (st__tos1_vld),
    .st__depth      (st__depth),
    .st__uflow      (st__uflow),
    .st__oflow      (st__oflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, commit on the rising edge,
  // then return inputs to idle so both builds show registered state when sampled.
  task automatic applyStimulus(input logic rst_i, input logic push_i,
                               input logic [10:0] pop_i, input logic [34:0] data_i);
    @(negedge clk);
    rst            = rst_i;
    st__push_5a    = push_i;
    st__to_pop_5a  = pop_i;
    st__to_push_5a = data_i;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    st__push_5a    = 1'b0;
    st__to_pop_5a  = '0;
    st__to_push_5a = '0;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [34:0] observed,
                             input logic [34:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst            = 1'b1;
    st__push_5a    = 1'b0;
    st__to_pop_5a  = '0;
    st__to_push_5a = '0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 11'd0, 35'h0);
    applyStimulus(1'b1, 1'b0, 11'd0, 35'h0);
    checkOutput("rst_depth",    35'(st__depth),    35'd0);
    checkOutput("rst_tos0",     st__tos0,          35'h0);
    checkOutput("rst_tos1",     st__tos1,          35'h0);
    checkOutput("rst_tos0_vld", 35'(st__tos0_vld), 35'd0);
    checkOutput("rst_tos1_vld", 35'(st__tos1_vld), 35'd0);
    checkOutput("rst_uflow",    35'(st__uflow),    35'd0);
    checkOutput("rst_oflow",    35'(st__oflow),    35'd0);

    // Two consecutive pushes
    applyStimulus(1'b0, 1'b1, 11'd0, 35'h1_0000_00AA);
    applyStimulus(1'b0, 1'b1, 11'd0, 35'h2_0000_00BB);
    checkOutput("t1_depth",    35'(st__depth),    35'd2);
    checkOutput("t1_tos0",     st__tos0,          35'h2_0000_00BB);
    checkOutput("t1_tos1",     st__tos1,          35'h1_0000_00AA);
    checkOutput("t1_tos0_vld", 35'(st__tos0_vld), 35'd1);
    checkOutput("t1_tos1_vld", 35'(st__tos1_vld), 35'd1);

    // Pop 0 without push changes nothing
    applyStimulus(1'b0, 1'b0, 11'd0, 35'h7_FFFF_FFFF);
    checkOutput("nop_depth", 35'(st__depth), 35'd2);
    checkOutput("nop_tos0",  st__tos0,       35'h2_0000_00BB);

    // Depth 3, then pop 2 + push in one cycle
    applyStimulus(1'b0, 1'b1, 11'd0, 35'h3_0000_00CC);
    checkOutput("t2_depth3", 35'(st__depth), 35'd3);
    applyStimulus(1'b0, 1'b1, 11'd2, 35'h0_DEAD_BEEF);
    checkOutput("t2_depth", 35'(st__depth), 35'd2);
    checkOutput("t2_tos0",  st__tos0,       35'h0_DEAD_BEEF);
    checkOutput("t2_tos1",  st__tos1,       35'h1_0000_00AA);
    checkOutput("t2_uflow", 35'(st__uflow), 35'd0);

    // Depth 1, then over-pop
    applyStimulus(1'b0, 1'b0, 11'd1, 35'h0);
    checkOutput("t3_depth1", 35'(st__depth), 35'd1);
    checkOutput("t3_tos0a",  st__tos0,       35'h1_0000_00AA);
    checkOutput("t3_tos1_vld", 35'(st__tos1_vld), 35'd0);
    applyStimulus(1'b0, 1'b0, 11'd5, 35'h0);
    checkOutput("t3_depth",    35'(st__depth),    35'd0);
    checkOutput("t3_uflow",    35'(st__uflow),    35'd1);
    checkOutput("t3_tos0_vld", 35'(st__tos0_vld), 35'd0);
    checkOutput("t3_tos0",     st__tos0,          35'h0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 11'd0, 35'h0);
    end
    checkOutput("t3_uflow_sticky", 35'(st__uflow), 35'd1);

    // Fill to 1024 entries, then overflow
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1'b0, 1'b1, 11'd0, 35'(i) | 35'h4_0000_0000);
    end
    checkOutput("t4_full_depth", 35'(st__depth), 35'd1024);
    checkOutput("t4_full_oflow", 35'(st__oflow), 35'd0);
    checkOutput("t4_full_tos0",  st__tos0,       35'h4_0000_03FF);
    checkOutput("t4_full_tos1",  st__tos1,       35'h4_0000_03FE);
    applyStimulus(1'b0, 1'b1, 11'd0, 35'h5_5555_5555);
    checkOutput("t4_ovf_depth", 35'(st__depth), 35'd1024);
    checkOutput("t4_ovf_oflow", 35'(st__oflow), 35'd1);
    checkOutput("t4_ovf_tos0",  st__tos0,       35'h4_0000_03FF);
    applyStimulus(1'b0, 1'b1, 11'd1, 35'h7_0000_0001);
    checkOutput("t4_rep_depth", 35'(st__depth), 35'd1024);
    checkOutput("t4_rep_tos0",  st__tos0,       35'h7_0000_0001);
    checkOutput("t4_rep_tos1",  st__tos1,       35'h4_0000_03FE);
    checkOutput("t4_rep_oflow", 35'(st__oflow), 35'd1);

    // Reset with a push in the same cycle at depth 4
    applyStimulus(1'b1, 1'b0, 11'd0, 35'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 11'd0, 35'h6_0000_0010 + 35'(i));
    end
    checkOutput("t5_depth4", 35'(st__depth), 35'd4);
    applyStimulus(1'b1, 1'b1, 11'd0, 35'h1_2222_2222);
    checkOutput("t5_depth",    35'(st__depth),    35'd0);
    checkOutput("t5_uflow",    35'(st__uflow),    35'd0);
    checkOutput("t5_oflow",    35'(st__oflow),    35'd0);
    checkOutput("t5_tos0_vld", 35'(st__tos0_vld), 35'd0);
    applyStimulus(1'b0, 1'b1, 11'd0, 35'h2_3333_3333);
    checkOutput("t5_post_depth",    35'(st__depth),    35'd1);
    checkOutput("t5_post_tos0",     st__tos0,          35'h2_3333_3333);
    checkOutput("t5_post_tos1_vld", 35'(st__tos1_vld), 35'd0);

`ifdef CPU_STACK_FWD_EN
    // Same-cycle forwarded view of a push onto an empty stack
    applyStimulus(1'b1, 1'b0, 11'd0, 35'h0);
    @(negedge clk);
    st__push_5a    = 1'b1;
    st__to_push_5a = 35'h3_1234_5678;
    #1;
    checkOutput("t6_tos0",     st__tos0,          35'h3_1234_5678);
    checkOutput("t6_depth",    35'(st__depth),    35'd1);
    checkOutput("t6_tos0_vld", 35'(st__tos0_vld), 35'd1);
    @(posedge clk);
    #1;
    st__push_5a    = 1'b0;
    st__to_push_5a = '0;
    #1;
    checkOutput("t6_reg_tos0", st__tos0, 35'h3_1234_5678);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
